// File: rtl/clk_div_line_gate_if.sv
// clk_div_line_gate_if: line pulse in, line gate out.
interface clk_div_line_gate_if;
  logic hsync_r_pos;
  logic clk_div;
  modport master (output hsync_r_pos, input clk_div);
  modport slave (input hsync_r_pos, output clk_div);
endinterface

// File: rtl/clk_div_line_gate.sv
// clk_div_line_gate: raises clk_div for one line in every DIV_N hsync pulses.
module clk_div_line_gate #(
  parameter int DIV_N = 2,
  parameter int PHASE = 1
) (
  input  logic vga_clk,
  input  logic rst_n,
  clk_div_line_gate_if.slave bus
);
  localparam int CNT_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  if (DIV_N < 1) begin : g_bad_div
    $error("clk_div_line_gate: DIV_N must be >= 1");
  end
  if (PHASE < 0 || PHASE >= DIV_N) begin : g_bad_phase
    $error("clk_div_line_gate: PHASE must be in 0..DIV_N-1");
  end
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  always_comb cnt_next = (cnt == CNT_W'(DIV_N - 1)) ? '0 : cnt + CNT_W'(1);
  // rst_n is active-high despite its name
  always_ff @(posedge vga_clk) begin
    if (rst_n) begin
      cnt <= '0;
      bus.clk_div <= 1'b0;
    end else if (bus.hsync_r_pos) begin
      cnt <= cnt_next;
      bus.clk_div <= (cnt_next == CNT_W'(PHASE));
    end
  end
endmodule

// File: tb/tb_clk_div_line_gate.sv
// tb_clk_div_line_gate: directed checks of four gate configurations driven in lockstep.
module tb_clk_div_line_gate;
  logic vga_clk = 1'b0;
  logic rst = 1'b0;
  logic hsync = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 vga_clk = ~vga_clk;
  clk_div_line_gate_if b2 ();
  clk_div_line_gate_if b3 ();
  clk_div_line_gate_if b1 ();
  clk_div_line_gate_if b4 ();
  assign b2.hsync_r_pos = hsync;
  assign b3.hsync_r_pos = hsync;
  assign b1.hsync_r_pos = hsync;
  assign b4.hsync_r_pos = hsync;
  clk_div_line_gate #(.DIV_N(2), .PHASE(1)) u2 (.vga_clk(vga_clk), .rst_n(rst), .bus(b2.slave));
  clk_div_line_gate #(.DIV_N(3), .PHASE(0)) u3 (.vga_clk(vga_clk), .rst_n(rst), .bus(b3.slave));
  clk_div_line_gate #(.DIV_N(1), .PHASE(0)) u1 (.vga_clk(vga_clk), .rst_n(rst), .bus(b1.slave));
  clk_div_line_gate #(.DIV_N(4), .PHASE(2)) u4 (.vga_clk(vga_clk), .rst_n(rst), .bus(b4.slave));
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask
  task automatic pulse;
    hsync = 1'b1;
    cyc(1);
    hsync = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask
  logic [3:0] exp2;
  logic [6:0] exp3;
  logic [4:0] exp4;
  initial begin
    #1;
    rst = 1'b1;
    hsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("reset_div2", b2.clk_div, 1'b0);
      check("reset_div1", b1.clk_div, 1'b0);
    end
    rst = 1'b0;
    hsync = 1'b0;
    cyc(3);
    check("post_reset_hold", b2.clk_div, 1'b0);
    exp2 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      pulse();
      check("toggle_edge", b2.clk_div, exp2[i]);
      cyc(799);
      check("toggle_hold", b2.clk_div, exp2[i]);
    end
    do_reset();
    exp3 = 7'b0100100;
    for (int i = 0; i < 7; i++) begin
      pulse();
      check("div3_seq", b3.clk_div, exp3[i]);
      cyc(2);
    end
    do_reset();
    hsync = 1'b1;
    cyc(1);
    check("b2b_div2_p1", b2.clk_div, 1'b1);
    cyc(1);
    check("b2b_div2_p2", b2.clk_div, 1'b0);
    cyc(1);
    check("b2b_div2_p3", b2.clk_div, 1'b1);
    check("b2b_div3_p3", b3.clk_div, 1'b1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    hsync = 1'b0;
    check("rst_priority_div2", b2.clk_div, 1'b0);
    check("rst_priority_div3", b3.clk_div, 1'b0);
    cyc(1);
    pulse();
    check("rst_restart_div2", b2.clk_div, 1'b1);
    do_reset();
    check("div1_reset", b1.clk_div, 1'b0);
    cyc(5);
    check("div1_idle", b1.clk_div, 1'b0);
    for (int i = 0; i < 11; i++) begin
      pulse();
      check("div1_high", b1.clk_div, 1'b1);
      cyc(3);
      check("div1_hold", b1.clk_div, 1'b1);
    end
    do_reset();
    pulse();
    check("div4_pre", b4.clk_div, 1'b0);
    cyc(2);
    do_reset();
    exp4 = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      pulse();
      check("div4_midreset", b4.clk_div, exp4[i]);
      cyc(4);
      check("div4_hold", b4.clk_div, exp4[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_line_gate.md
Name: clk_div_line_gate

Overview:
- Line-rate gate generator in the vga_clk domain.
- Counts per-line hsync rising-edge pulses (hsync_r_pos) modulo DIV_N.
- Raises a level output, clk_div, for one line in every DIV_N lines.
- The finger-detection datapath ANDs clk_div into its edge-buffer write enable, so only every DIV_N-th scan line updates the buffer.

Parameters:
- DIV_N, 2: line division ratio. Legal range 1..1024.
- PHASE, 1: counter value at which clk_div is high. Legal range 0..DIV_N-1.
- CNT_W, derived: max(1, ceil(log2(DIV_N))). Not user-overridable.

Ports:
- vga_clk  input  1  pixel clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1).
- hsync_r_pos  input  1  single-cycle pulse marking each hsync rising edge (one per line).
- clk_div  output  1  registered line gate; high during selected lines.

Behaviour:
- Single clock domain (vga_clk). Reset is synchronous active-high; no asynchronous paths.
- State:
  - line counter cnt[CNT_W-1:0].
  - output register clk_div.
- Reset (rst_n = 1 at a rising edge): cnt <= 0, clk_div <= 0. Reset takes priority over a simultaneous hsync_r_pos.
- Not in reset, hsync_r_pos = 1:
  - cnt_next = (cnt == DIV_N-1) ? 0 : cnt + 1.
  - cnt <= cnt_next.
  - clk_div <= (cnt_next == PHASE).
- Not in reset, hsync_r_pos = 0: cnt and clk_div hold.
- Latency: clk_div reflects a pulse on the clock edge that samples hsync_r_pos high, i.e. it is valid from the next cycle.
- Default (DIV_N = 2, PHASE = 1): clk_div toggles on every pulse. The sequence after reset is 0 → 1 → 0 → 1…, so the first line after reset is enabled.
- DIV_N = 1 (PHASE must be 0): cnt stays 0, clk_div goes to 1 on the first pulse and stays 1.
- Back-to-back pulses on consecutive cycles: each pulse counts; no pulse merging or filtering.
- Wrap-around: cnt never exceeds DIV_N-1, including when DIV_N is not a power of two.
- Reset mid-line: clk_div drops to 0 on the reset edge and the counting phase restarts from 0.
- Parameter checks at elaboration (generate-time error):
  - DIV_N < 1.
  - PHASE >= DIV_N.
- No combinational path from inputs to clk_div.
- clk_div is a level, not a pulse.

Test Plan:
- Reset: hold rst_n = 1 for 3 cycles with hsync_r_pos pulsing → clk_div = 0 throughout and cnt = 0 after release.
- Default toggle: DIV_N = 2, PHASE = 1, pulses every 800 cycles → clk_div = 1, 0, 1, 0 after pulses 1..4; each change appears the cycle after the pulse sample and holds between pulses.
- Non-power-of-two ratio: DIV_N = 3, PHASE = 0, 7 pulses → clk_div high only after pulses 3 and 6; cnt sequence 1, 2, 0, 1, 2, 0, 1.
- Back-to-back and reset priority: DIV_N = 2, hsync_r_pos high for 3 consecutive cycles → clk_div 1, 0, 1. Then assert rst_n together with a pulse → clk_div = 0 and cnt = 0 next cycle.
- Degenerate ratio: DIV_N = 1, PHASE = 0 → clk_div = 0 until the first pulse, then constantly 1 across 10 further pulses.
- Mid-sequence reset: DIV_N = 4, PHASE = 2, reset after 1 pulse → post-reset clk_div first goes high after the 2nd subsequent pulse and falls after the 3rd.
